// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
// Shift level k is applied in stage floor(k*STAGES/SHAMT_W); a stall freezes every stage.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STAGES  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               result_zero
);

    typedef enum logic [1:0] {
        ModeSll = 2'b00,
        ModeSrl = 2'b01,
        ModeSra = 2'b10,
        ModeRor = 2'b11
    } mode_e;

    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input mode_e            mode,
                                                     input logic             sign,
                                                     input int unsigned      amt);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        ones = '1;
        case (mode)
            ModeSll: res = d << amt;
            ModeSrl: res = d >> amt;
            ModeSra: res = (d >> amt) | (sign ? ~(ones >> amt) : '0);
            default: res = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return res;
    endfunction

    logic [WIDTH-1:0]   data_q  [STAGES];
    logic [WIDTH-1:0]   data_d  [STAGES];
    logic [SHAMT_W-1:0] shamt_q [STAGES];
    logic [SHAMT_W-1:0] shamt_d [STAGES];
    mode_e              mode_q  [STAGES];
    mode_e              mode_d  [STAGES];
    logic               sign_q  [STAGES];
    logic               sign_d  [STAGES];
    logic               valid_q [STAGES];
    logic               valid_d [STAGES];
    logic               zero_q;
    logic               zero_d;
    logic               stall;

    always_comb begin
        stall    = valid_q[STAGES-1] & ~out_ready;
        in_ready = ~stall & reset;

        data_d[0]  = data_operandA;
        shamt_d[0] = ctrl_shiftamt;
        mode_d[0]  = mode_e'(ctrl_mode);
        sign_d[0]  = data_operandA[WIDTH-1];
        valid_d[0] = in_valid & in_ready;
        for (int s = 1; s < int'(STAGES); s++) begin
            data_d[s]  = data_q[s-1];
            shamt_d[s] = shamt_q[s-1];
            mode_d[s]  = mode_q[s-1];
            sign_d[s]  = sign_q[s-1];
            valid_d[s] = valid_q[s-1];
        end

        // SRA fills with the operand's original sign at every level, not the partial result's MSB.
        for (int s = 0; s < int'(STAGES); s++) begin
            for (int k = 0; k < int'(SHAMT_W); k++) begin
                if ((k * int'(STAGES)) / int'(SHAMT_W) == s && shamt_d[s][k]) begin
                    data_d[s] = shift_level(data_d[s], mode_d[s], sign_d[s], 1 << k);
                end
            end
        end

        zero_d = (data_d[STAGES-1] == '0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                data_q[s]  <= '0;
                shamt_q[s] <= '0;
                mode_q[s]  <= ModeSll;
                sign_q[s]  <= 1'b0;
                valid_q[s] <= 1'b0;
            end
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                shamt_q[s] <= shamt_d[s];
                mode_q[s]  <= mode_d[s];
                sign_q[s]  <= sign_d[s];
                valid_q[s] <= valid_d[s];
            end
            for (int s = 0; s < int'(STAGES) - 1; s++) begin
                data_q[s] <= data_d[s];
            end
            // Output register only loads real results so it reads 0 until the first one.
            if (valid_d[STAGES-1]) begin
                data_q[STAGES-1] <= data_d[STAGES-1];
                zero_q           <= zero_d;
            end
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign data_result = data_q[STAGES-1];
    assign result_zero = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench: two shifter instances (32-bit/5-stage and 16-bit/2-stage) checked
// against a plain-arithmetic scoreboard model every cycle, plus literal expectations.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_v  [2];
    logic        out_ready_v [2];
    logic [31:0] a_v         [2];
    logic [4:0]  sh_v        [2];
    logic [1:0]  mode_v      [2];
    bit          hl_v        [2];
    logic [31:0] lit_v       [2];

    logic        in_ready0, out_valid0, zero0;
    logic [31:0] res0;
    logic        in_ready1, out_valid1, zero1;
    logic [15:0] res1;

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES(5)) dut (
        .clock         (clk),
        .reset         (rst_n),
        .in_valid      (in_valid_v[0]),
        .in_ready      (in_ready0),
        .data_operandA (a_v[0]),
        .ctrl_shiftamt (sh_v[0]),
        .ctrl_mode     (mode_v[0]),
        .out_valid     (out_valid0),
        .out_ready     (out_ready_v[0]),
        .data_result   (res0),
        .result_zero   (zero0)
    );

    pipelined_barrel_shifter #(.WIDTH(16), .STAGES(2)) dut16 (
        .clock         (clk),
        .reset         (rst_n),
        .in_valid      (in_valid_v[1]),
        .in_ready      (in_ready1),
        .data_operandA (a_v[1][15:0]),
        .ctrl_shiftamt (sh_v[1][3:0]),
        .ctrl_mode     (mode_v[1]),
        .out_valid     (out_valid1),
        .out_ready     (out_ready_v[1]),
        .data_result   (res1),
        .result_zero   (zero1)
    );

    typedef struct {
        logic [31:0] exp;
        logic [31:0] lit;
        bit          has_lit;
        int          acc_cyc;
        int          acc_stall;
    } entry_t;

    entry_t      q0[$];
    entry_t      q1[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          stall_cnt [2];
    bit          prev_stall [2];
    bit          post_rst [2];
    logic [31:0] prev_res [2];
    bit          rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] vld_of(int d);
        return {31'b0, (d == 0) ? out_valid0 : out_valid1};
    endfunction
    function automatic logic [31:0] rdy_of(int d);
        return {31'b0, (d == 0) ? in_ready0 : in_ready1};
    endfunction
    function automatic logic [31:0] zf_of(int d);
        return {31'b0, (d == 0) ? zero0 : zero1};
    endfunction
    function automatic logic [31:0] res_of(int d);
        return (d == 0) ? res0 : {16'h0, res1};
    endfunction

    function automatic int sb_size(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction
    function automatic entry_t sb_front(int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction
    task automatic sb_pop(input int d);
        if (d == 0) q0.delete(0); else q1.delete(0);
    endtask
    task automatic sb_push(input int d, input entry_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask
    task automatic sb_clear(input int d);
        if (d == 0) q0.delete(); else q1.delete();
    endtask

    // Reference result straight from the mode definitions using wide arithmetic.
    function automatic logic [31:0] model(int w, logic [31:0] a, int sh, logic [1:0] m);
        logic [63:0]        mask;
        logic [63:0]        x;
        logic signed [63:0] sx;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'h0, a} & mask;
        case (m)
            2'b00:   return 32'((x << sh) & mask);
            2'b01:   return 32'(x >> sh);
            2'b10: begin
                sx = x[w-1] ? (x | ~mask) : x;
                sx = sx >>> sh;
                return 32'(sx & mask);
            end
            default: return 32'(((x | (x << w)) >> sh) & mask);
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, act, exp);
        end
    endtask

    task automatic mon(input int d);
        entry_t e;
        bit     stall;
        int     w;
        int     st;
        w     = (d == 0) ? 32 : 16;
        st    = (d == 0) ? 5 : 2;
        stall = (vld_of(d) != 0) && !out_ready_v[d];
        if (post_rst[d]) begin
            chk("reset_out_valid", d, vld_of(d), 32'd0);
            chk("reset_result", d, res_of(d), 32'd0);
            chk("reset_zero", d, zf_of(d), 32'd0);
        end
        if (!rst_n) begin
            chk("in_ready_in_reset", d, rdy_of(d), 32'd0);
            sb_clear(d);
            post_rst[d]   = 1'b1;
            prev_stall[d] = 1'b0;
            return;
        end
        post_rst[d] = 1'b0;
        chk("in_ready", d, rdy_of(d), {31'b0, !stall});
        if (prev_stall[d]) begin
            chk("stall_hold_valid", d, vld_of(d), 32'd1);
            chk("stall_hold_result", d, res_of(d), prev_res[d]);
        end
        if (vld_of(d) != 0) begin
            tests++;
            if (sb_size(d) == 0) begin
                fails++;
                $display("FAIL spurious_result dut%0d cyc=%0d got=%h want=no_result",
                         d, cyc, res_of(d));
            end else if (out_ready_v[d]) begin
                e = sb_front(d);
                sb_pop(d);
                chk("result", d, res_of(d), e.exp);
                chk("zero_flag", d, zf_of(d), {31'b0, e.exp == 32'd0});
                chk("latency", d, 32'(cyc - e.acc_cyc), 32'(st + stall_cnt[d] - e.acc_stall));
                if (e.has_lit) chk("literal", d, res_of(d), e.lit);
            end
        end else if (sb_size(d) > 0) begin
            e = sb_front(d);
            if (cyc - e.acc_cyc >= st + stall_cnt[d] - e.acc_stall) begin
                tests++;
                fails++;
                $display("FAIL missing_result dut%0d cyc=%0d got=no_valid want=%h", d, cyc, e.exp);
                sb_pop(d);
            end
        end
        if (stall) stall_cnt[d]++;
        prev_stall[d] = stall;
        prev_res[d]   = res_of(d);
        if (in_valid_v[d] && rdy_of(d) != 0) begin
            e.exp       = model(w, a_v[d], int'(sh_v[d]), mode_v[d]);
            e.lit       = lit_v[d];
            e.has_lit   = hl_v[d];
            e.acc_cyc   = cyc;
            e.acc_stall = stall_cnt[d];
            sb_push(d, e);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready_v[0] = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int d, input logic [1:0] m, input logic [31:0] a,
                        input logic [4:0] sh, input bit hl, input logic [31:0] lit);
        int n;
        bit ok;
        n = 0;
        in_valid_v[d] = 1'b1;
        a_v[d]        = a;
        sh_v[d]       = sh;
        mode_v[d]     = m;
        hl_v[d]       = hl;
        lit_v[d]      = lit;
        do begin
            @(negedge clk);
            ok = (rdy_of(d) != 0);
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout dut%0d cyc=%0d got=in_ready_low want=accept", d, cyc);
        end
        in_valid_v[d] = 1'b0;
        hl_v[d]       = 1'b0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sb_size(d) != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_size(d) != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout dut%0d cyc=%0d got=%0d_pending want=0", d, cyc, sb_size(d));
        end
    endtask

    logic [1:0]  vm [13];
    logic [31:0] va [13];
    logic [4:0]  vs [13];
    logic [31:0] vl [13];

    initial begin
        vm = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
        va = '{32'h8000_0000, 32'h7FFF_FFF0, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001,
               32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
               32'h0000_0003, 32'h0000_0001, 32'h0000_ABCD};
        vs = '{5'd31, 5'd4, 5'd4, 5'd31, 5'd1, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd1, 5'd16};
        vl = '{32'hFFFF_FFFF, 32'h07FF_FFFF, 32'h0800_0000, 32'h8000_0000, 32'h8000_0000,
               32'h7812_3456, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
               32'h8000_0000, 32'h0000_0000, 32'hABCD_0000};
        stall_cnt = '{0, 0};
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d]  = 1'b0;
            out_ready_v[d] = 1'b1;
            a_v[d]         = '0;
            sh_v[d]        = '0;
            mode_v[d]      = '0;
            hl_v[d]        = 1'b0;
            lit_v[d]       = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) send(0, vm[i], va[i], vs[i], 1'b1, vl[i]);
        drain(0);

        // Backpressure: three back-to-back ops, consumer stalls 4 cycles on the first result.
        send(0, 2'd1, 32'hF000_000F, 5'd3, 1'b1, 32'h1E00_0001);
        send(0, 2'd0, 32'h0000_00FF, 5'd8, 1'b1, 32'h0000_FF00);
        send(0, 2'd3, 32'h0000_00F0, 5'd4, 1'b1, 32'h0000_000F);
        out_ready_v[0] = 1'b0;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid0 && n < 20);
        end
        repeat (4) @(posedge clk);
        #1;
        out_ready_v[0] = 1'b1;
        drain(0);

        // Reset with three ops in flight; none may emerge, and a fresh op sees normal latency.
        send(0, 2'd2, 32'h8000_0000, 5'd1, 1'b0, 32'h0);
        send(0, 2'd1, 32'hFFFF_FFFF, 5'd2, 1'b0, 32'h0);
        send(0, 2'd0, 32'h0000_0001, 5'd5, 1'b0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send(0, 2'd2, 32'hC000_0000, 5'd30, 1'b1, 32'hFFFF_FFFF);
        drain(0);

        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(0, 2'($urandom_range(0, 3)), a, 5'($urandom_range(0, 31)), 1'b0, 32'h0);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b1;
        drain(0);

        send(1, 2'd2, 32'h0000_8000, 5'd15, 1'b1, 32'h0000_FFFF);
        send(1, 2'd3, 32'h0000_1234, 5'd4, 1'b1, 32'h0000_4123);
        drain(1);
        for (int i = 0; i < 8; i++) begin
            send(1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 65535)),
                 5'($urandom_range(0, 15)), 1'b0, 32'h0);
        end
        drain(1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
